// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package rf_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_NUM_RD   = 4;
  localparam int DEF_NUM_WR   = 2;
  localparam int DEF_PC_IDX   = 7;
  localparam logic [15:0] DEF_PC_RESET = 16'h0002;

  // Widest port vector the priority helper accepts.
  localparam int MAX_PORTS = 32;

  // Highest-indexed set bit wins; -1 when no port is requesting.
  function automatic int prio_winner(input logic [MAX_PORTS-1:0] hits);
    int w;
    w = -1;
    for (int j = 0; j < MAX_PORTS; j++) begin
      if (hits[j]) w = j;
    end
    return w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set by dispatch, cleared by writeback or flush.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_WR   = DEF_NUM_WR
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_WR-1:0]          alloc_en,
  input  logic [NUM_WR*ADDR_W-1:0]   alloc_addr,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic                       flush,
  output logic [NUM_REGS-1:0]        busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] alloc_hit;
  logic [NUM_REGS-1:0] clr_hit;

  // Decode which registers are targeted by any alloc or writeback port;
  // out-of-range addresses never match a real register index.
  always_comb begin
    alloc_hit = '0;
    clr_hit   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (alloc_en[j] && (alloc_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) alloc_hit[r] = 1'b1;
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)))       clr_hit[r]   = 1'b1;
      end
    end
  end

  // Alloc marks a newer producer, so it outranks both flush and writeback clear.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (alloc_hit[r])      busy_d[r] = 1'b1;
      else if (flush)        busy_d[r] = 1'b0;
      else if (clr_hit[r])   busy_d[r] = 1'b0;
    end
  end

  // Busy state register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_scoreboarded.sv
// Multi-ported architectural register file with busy scoreboard, write
// priority (highest port wins) and optional write-to-read bypass.
module regfile_scoreboarded
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int BYPASS   = 1,
  parameter int PC_IDX   = DEF_PC_IDX,
  parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(DEF_PC_RESET)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR-1:0]          alloc_en,
  input  logic [NUM_WR*ADDR_W-1:0]   alloc_addr,
  input  logic                       flush,
  output logic [NUM_REGS-1:0]        busy_vec
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_WR-1:0] wr_hit [NUM_REGS];
  int                wr_win [NUM_REGS];

  logic [ADDR_W-1:0] rd_a   [NUM_RD];
  logic [NUM_WR-1:0] rd_hit [NUM_RD];
  int                rd_win [NUM_RD];

  // Per-register write-port match; out-of-range addresses match nothing.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) wr_hit[r][j] = 1'b1;
      end
    end
  end

  // Next register contents: the highest enabled port on a collision wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      wr_win[r] = prio_winner(MAX_PORTS'(wr_hit[r]));
      if (wr_win[r] >= 0) regs_d[r] = wr_data[wr_win[r]*DATA_W +: DATA_W];
    end
  end

  // Register array; reset clears everything except the PC, which gets its boot vector.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= (r == PC_IDX) ? PC_RESET : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports with optional same-cycle forwarding of write data;
  // a forwarded value also masks the busy bit since the producer is completing now.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_a[i]   = rd_addr[i*ADDR_W +: ADDR_W];
      rd_hit[i] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_a[i])) rd_hit[i][j] = 1'b1;
      end
      rd_win[i] = prio_winner(MAX_PORTS'(rd_hit[i]));
      if (int'(rd_a[i]) < NUM_REGS) begin
        rd_data[i*DATA_W +: DATA_W] = regs_q[rd_a[i]];
        rd_busy[i]                  = busy_vec[rd_a[i]];
        if ((BYPASS != 0) && (rd_win[i] >= 0)) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data[rd_win[i]*DATA_W +: DATA_W];
          rd_busy[i]                  = 1'b0;
        end
      end
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

endmodule
